// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared widths, control-bundle type and helpers for the MEM stage
//            and its data memory.
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  localparam int C_DMEM_ADDR_W = 8;   // byte address taken from ALU_result
  localparam int C_REG_IDX_W   = 5;   // register file index width
  localparam int C_CNT_W       = 16;  // access counter width

  // Control flags travelling with an instruction through EX/MEM.
  typedef struct packed {
    logic reg_write;
    logic branch;
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
  } mem_ctl_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [C_CNT_W-1:0] sat_inc(input logic [C_CNT_W-1:0] v);
    return (&v) ? v : v + C_CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : data_mem
// Purpose  : DMEM_DEPTH x 8 data memory, synchronous write, asynchronous read.
//            The byte address wraps modulo DMEM_DEPTH. Contents have no reset.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DMEM_DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [C_DMEM_ADDR_W-1:0] addr,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata
);

  localparam int IDX_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [7:0]       mem_q [DMEM_DEPTH];
  logic [IDX_W-1:0] idx;

  // Fold the 8-bit byte address onto the physical depth.
  assign idx = IDX_W'(32'(addr) % DMEM_DEPTH);

  // Byte write on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : EX/MEM pipeline register, branch resolution, data memory access
//            and MEM/WB pipeline register. Stall holds EX/MEM and bubbles
//            MEM/WB; flush kills the instruction entering EX/MEM.
// Options  : MEM_ACCESS_CNT_EN - adds saturating load_count / store_count.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int PC_SIZE    = 10,
  parameter int DMEM_DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     valid_in,
  input  logic [PC_SIZE-1:0]       PC_jump,
  input  logic                     zero,
  input  logic [7:0]               ALU_result,
  input  logic [7:0]               store_data,
  input  logic [C_REG_IDX_W-1:0]   rd_in,
  input  logic                     reg_write_in,
  input  logic                     branch_in,
  input  logic                     mem_read_in,
  input  logic                     mem_to_reg_in,
  input  logic                     mem_write_in,
  output logic                     pc_src,
  output logic [PC_SIZE-1:0]       PC_target,
  output logic [7:0]               read_data_out,
  output logic [7:0]               ALU_result_out,
  output logic [C_REG_IDX_W-1:0]   rd_out,
  output logic                     reg_write_out,
  output logic                     mem_to_reg_out,
  output logic                     valid_out
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [C_CNT_W-1:0]       load_count,
  output logic [C_CNT_W-1:0]       store_count
`endif
);

  // EX/MEM register
  logic                   valid_m_q, valid_m_d;
  logic [PC_SIZE-1:0]     pc_jump_m_q, pc_jump_m_d;
  logic                   zero_m_q, zero_m_d;
  logic [7:0]             alu_m_q, alu_m_d;
  logic [7:0]             store_m_q, store_m_d;
  logic [C_REG_IDX_W-1:0] rd_m_q, rd_m_d;
  mem_ctl_t               ctl_m_q, ctl_m_d;

  // MEM/WB register
  logic                   valid_w_q, valid_w_d;
  logic                   reg_write_w_q, reg_write_w_d;
  logic                   mem_to_reg_w_q, mem_to_reg_w_d;
  logic [C_REG_IDX_W-1:0] rd_w_q, rd_w_d;
  logic [7:0]             alu_w_q, alu_w_d;
  logic [7:0]             rdata_w_q, rdata_w_d;

  logic       w_commit;
  logic       w_dmem_we;
  logic [7:0] w_dmem_rdata;

  // An instruction in EX/MEM takes effect only on a non-stalled edge, so a
  // held store writes once, on the edge that releases it.
  assign w_commit  = valid_m_q & ~stall;
  assign w_dmem_we = w_commit & ctl_m_q.mem_write & ~rst;

  // EX/MEM next state: capture unless stalled; flush always clears valid.
  always_comb begin
    valid_m_d   = valid_m_q;
    pc_jump_m_d = pc_jump_m_q;
    zero_m_d    = zero_m_q;
    alu_m_d     = alu_m_q;
    store_m_d   = store_m_q;
    rd_m_d      = rd_m_q;
    ctl_m_d     = ctl_m_q;
    if (!stall) begin
      valid_m_d   = valid_in;
      pc_jump_m_d = PC_jump;
      zero_m_d    = zero;
      alu_m_d     = ALU_result;
      store_m_d   = store_data;
      rd_m_d      = rd_in;
      ctl_m_d     = '{reg_write:  reg_write_in,
                      branch:     branch_in,
                      mem_read:   mem_read_in,
                      mem_to_reg: mem_to_reg_in,
                      mem_write:  mem_write_in};
    end
    if (flush) begin
      valid_m_d = 1'b0;
    end
  end

  // EX/MEM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_m_q   <= 1'b0;
      pc_jump_m_q <= '0;
      zero_m_q    <= 1'b0;
      alu_m_q     <= '0;
      store_m_q   <= '0;
      rd_m_q      <= '0;
      ctl_m_q     <= '0;
    end else begin
      valid_m_q   <= valid_m_d;
      pc_jump_m_q <= pc_jump_m_d;
      zero_m_q    <= zero_m_d;
      alu_m_q     <= alu_m_d;
      store_m_q   <= store_m_d;
      rd_m_q      <= rd_m_d;
      ctl_m_q     <= ctl_m_d;
    end
  end

  data_mem #(
    .DMEM_DEPTH (DMEM_DEPTH)
  ) u_data_mem (
    .clk   (clk),
    .we    (w_dmem_we),
    .addr  (alu_m_q),
    .wdata (store_m_q),
    .rdata (w_dmem_rdata)
  );

  // MEM/WB next state: bubble on stall; reg_write never survives without
  // valid. Non-loads latch zero read data so no stale memory byte reaches WB.
  always_comb begin
    valid_w_d      = 1'b0;
    reg_write_w_d  = 1'b0;
    mem_to_reg_w_d = mem_to_reg_w_q;
    rd_w_d         = rd_w_q;
    alu_w_d        = alu_w_q;
    rdata_w_d      = rdata_w_q;
    if (!stall) begin
      valid_w_d      = valid_m_q;
      reg_write_w_d  = valid_m_q & ctl_m_q.reg_write;
      mem_to_reg_w_d = ctl_m_q.mem_to_reg;
      rd_w_d         = rd_m_q;
      alu_w_d        = alu_m_q;
      rdata_w_d      = ctl_m_q.mem_read ? w_dmem_rdata : 8'h00;
    end
  end

  // MEM/WB state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_w_q      <= 1'b0;
      reg_write_w_q  <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
      rd_w_q         <= '0;
      alu_w_q        <= '0;
      rdata_w_q      <= '0;
    end else begin
      valid_w_q      <= valid_w_d;
      reg_write_w_q  <= reg_write_w_d;
      mem_to_reg_w_q <= mem_to_reg_w_d;
      rd_w_q         <= rd_w_d;
      alu_w_q        <= alu_w_d;
      rdata_w_q      <= rdata_w_d;
    end
  end

  assign pc_src         = valid_m_q & ctl_m_q.branch & zero_m_q & ~stall;
  assign PC_target      = pc_jump_m_q;
  assign read_data_out  = rdata_w_q;
  assign ALU_result_out = alu_w_q;
  assign rd_out         = rd_w_q;
  assign reg_write_out  = reg_write_w_q;
  assign mem_to_reg_out = mem_to_reg_w_q;
  assign valid_out      = valid_w_q;

`ifdef MEM_ACCESS_CNT_EN
  logic [C_CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [C_CNT_W-1:0] store_cnt_q, store_cnt_d;

  // Count committed loads and stores, saturating at all-ones.
  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (w_commit & ctl_m_q.mem_read) begin
      load_cnt_d = sat_inc(load_cnt_q);
    end
    if (w_commit & ctl_m_q.mem_write) begin
      store_cnt_d = sat_inc(store_cnt_q);
    end
  end

  // Access counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign load_count  = load_cnt_q;
  assign store_count = store_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Scoreboard bench for mem_stage. Directed instructions push their
//            expected writeback record; a negedge monitor pops and compares
//            each retirement. Branch, stall, flush and reset behaviour is
//            checked directly. Counter checks exist when MEM_ACCESS_CNT_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, stall, flush, valid_in, zero;
  logic       reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in;
  logic [9:0] PC_jump;
  logic [7:0] ALU_result, store_data;
  logic [4:0] rd_in;
  logic       pc_src, reg_write_out, mem_to_reg_out, valid_out;
  logic [9:0] PC_target;
  logic [7:0] read_data_out, ALU_result_out;
  logic [4:0] rd_out;
`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] load_count, store_count;
`endif

  mem_stage #(.PC_SIZE(10), .DMEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .PC_jump(PC_jump), .zero(zero), .ALU_result(ALU_result),
    .store_data(store_data), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .branch_in(branch_in), .mem_read_in(mem_read_in),
    .mem_to_reg_in(mem_to_reg_in), .mem_write_in(mem_write_in),
    .pc_src(pc_src), .PC_target(PC_target), .read_data_out(read_data_out),
    .ALU_result_out(ALU_result_out), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .valid_out(valid_out)
`ifdef MEM_ACCESS_CNT_EN
    , .load_count(load_count), .store_count(store_count)
`endif
  );

  typedef struct {
    logic [7:0] rdat;
    logic       chk_rd;
    logic [7:0] alu;
    logic [4:0] rd;
    logic       rw;
    logic       m2r;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl [256];
  int         vectors     = 0;
  int         miscompares = 0;
  bit         mon_en      = 1'b1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Drive one instruction (stall/flush low), record its expected retirement
  // when requested, and advance past the capturing edge.
  task automatic issue(input logic v, input logic br, input logic z,
                       input logic mr, input logic mw, input logic rw,
                       input logic m2r, input logic [9:0] pj,
                       input logic [7:0] alu, input logic [7:0] sd,
                       input logic [4:0] rd, input bit push);
    exp_t e;
    valid_in = v; branch_in = br; zero = z; mem_read_in = mr;
    mem_write_in = mw; reg_write_in = rw; mem_to_reg_in = m2r;
    PC_jump = pj; ALU_result = alu; store_data = sd; rd_in = rd;
    stall = 1'b0; flush = 1'b0;
    if (push && v) begin
      e.rdat = mdl[alu]; e.chk_rd = mr; e.alu = alu; e.rd = rd;
      e.rw = rw; e.m2r = m2r;
      sb.push_back(e);
      if (mw) mdl[alu] = sd;
    end
    @(posedge clk); #1;
  endtask

  task automatic bubble();
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 8'h00, 8'h00, 5'd0, 1'b0);
  endtask

  // Writeback monitor: every retirement must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en && !rst) begin
      vectors++;
      if (valid_out) begin
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL wb_unexpected: got retire rd=%0d alu=0x%0h, expected no retirement",
                   rd_out, ALU_result_out);
        end else begin
          e = sb.pop_front();
          if (ALU_result_out !== e.alu || rd_out !== e.rd || reg_write_out !== e.rw ||
              mem_to_reg_out !== e.m2r || (e.chk_rd && read_data_out !== e.rdat)) begin
            miscompares++;
            $display("FAIL wb_record: got alu=0x%0h rd=%0d rw=%0b m2r=%0b data=0x%0h, expected alu=0x%0h rd=%0d rw=%0b m2r=%0b data=0x%0h",
                     ALU_result_out, rd_out, reg_write_out, mem_to_reg_out, read_data_out,
                     e.alu, e.rd, e.rw, e.m2r, e.rdat);
          end
        end
      end else if (reg_write_out) begin
        miscompares++;
        $display("FAIL rw_without_valid: got reg_write_out=1, expected 0");
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    foreach (mdl[i]) mdl[i] = 8'h00;
    rst = 1'b0; stall = 1'b0; flush = 1'b0; valid_in = 1'b0; zero = 1'b0;
    reg_write_in = 1'b0; branch_in = 1'b0; mem_read_in = 1'b0;
    mem_to_reg_in = 1'b0; mem_write_in = 1'b0; PC_jump = '0;
    ALU_result = '0; store_data = '0; rd_in = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {pc_src, reg_write_out, mem_to_reg_out, valid_out, rd_out}, 0);
    chk("reset_data", {PC_target, read_data_out, ALU_result_out}, 0);
`ifdef MEM_ACCESS_CNT_EN
    chk("reset_counts", {load_count, store_count}, 0);
`endif
    rst = 1'b0;

    // Store 0x5A @0x10, then load it back; then a plain ALU op.
    issue(1, 0, 0, 0, 1, 0, 0, 10'h0, 8'h10, 8'h5A, 5'd0, 1);
    issue(1, 0, 0, 1, 0, 1, 1, 10'h0, 8'h10, 8'h00, 5'd5, 1);
    issue(1, 0, 0, 0, 0, 1, 0, 10'h0, 8'hA5, 8'h00, 5'd7, 1);

    // Taken branch, stall gating of pc_src, then an untaken branch.
    issue(1, 1, 1, 0, 0, 0, 0, 10'h0F4, 8'h00, 8'h00, 5'd0, 1);
    chk("br_taken_pc_src", pc_src, 1);
    chk("br_taken_target", PC_target, 10'h0F4);
    stall = 1'b1; valid_in = 1'b0;
    #1 chk("br_stall_pc_src", pc_src, 0);
    issue(1, 1, 0, 0, 0, 0, 0, 10'h033, 8'h00, 8'h00, 5'd0, 1);
    chk("br_untaken_pc_src", pc_src, 0);
    chk("br_untaken_target", PC_target, 10'h033);

    // Store 0x11 @0x20, then store 0x33 @0x20 held three cycles by stall.
    issue(1, 0, 0, 0, 1, 0, 0, 10'h0, 8'h20, 8'h11, 5'd0, 1);
    issue(1, 0, 0, 0, 1, 0, 0, 10'h0, 8'h20, 8'h33, 5'd0, 1);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; valid_in = 1'b1; mem_write_in = 1'b1; reg_write_in = 1'b1;
      ALU_result = 8'h20; store_data = 8'h99; rd_in = 5'd9;
      @(posedge clk); #1;
      chk("stall_valid_out", valid_out, 0);
      chk("stall_reg_write", reg_write_out, 0);
    end
    issue(1, 0, 0, 1, 0, 1, 1, 10'h0, 8'h20, 8'h00, 5'd3, 1);
    bubble();
    bubble();

    // Flush together with stall kills a taken branch sitting in EX/MEM.
    issue(1, 1, 1, 0, 0, 0, 0, 10'h155, 8'h00, 8'h00, 5'd0, 0);
    chk("flush_pre_pc_src", pc_src, 1);
    flush = 1'b1; stall = 1'b1;
    @(posedge clk); #1;
    chk("flush_bubble_valid", valid_out, 0);
    flush = 1'b0; stall = 1'b0; valid_in = 1'b0;
    #1 chk("flush_pc_src", pc_src, 0);
    @(posedge clk); #1;
    chk("flush_next_valid", valid_out, 0);
    bubble();

    // Reset mid-operation: ALU op in MEM/WB, taken branch+store in EX/MEM.
    issue(1, 0, 0, 0, 0, 1, 0, 10'h0, 8'h3C, 8'h00, 5'd4, 0);
    issue(1, 1, 1, 0, 1, 0, 0, 10'h0AB, 8'h10, 8'hEE, 5'd0, 0);
    chk("pre_rst_pc_src", pc_src, 1);
    chk("pre_rst_valid", valid_out, 1);
    valid_in = 1'b0; branch_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_ctl", {pc_src, reg_write_out, mem_to_reg_out, valid_out, rd_out}, 0);
    chk("rst_data", {PC_target, read_data_out, ALU_result_out}, 0);
`ifdef MEM_ACCESS_CNT_EN
    chk("rst_counts", {load_count, store_count}, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();

    // Memory survives reset and the killed store never landed.
    issue(1, 0, 0, 1, 0, 1, 1, 10'h0, 8'h10, 8'h00, 5'd1, 1);
    issue(1, 0, 0, 1, 0, 1, 1, 10'h0, 8'h20, 8'h00, 5'd2, 1);
    bubble();
    bubble();
    bubble();
`ifdef MEM_ACCESS_CNT_EN
    chk("cnt_loads_2", load_count, 16'd2);
    chk("cnt_stores_0", store_count, 16'd0);
    mon_en = 1'b0;
    valid_in = 1'b1; mem_read_in = 1'b1; mem_to_reg_in = 1'b1;
    reg_write_in = 1'b1; ALU_result = 8'h10; rd_in = 5'd6;
    repeat (70000) @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("cnt_load_sat", load_count, 16'hFFFF);
    chk("cnt_store_still_0", store_count, 16'd0);
    mon_en = 1'b1;
`endif
    bubble();
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
